// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the CPU control unit:
//   opclass_t   - opcode classes presented by the PU on op_i
//   jmp_func_t  - JUMP-class function codes (5..7 decode as NOP)
//   ctrl_func_t - CTRL-class function codes (2..6 decode as NOP)
//   state_t     - sequencer states
//   REGMUX_*    - writeback source select values for RegMux_o
//   jump_taken  - branch condition evaluation against the latched Z/C flags
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ALU_RR = 3'd0,
    OP_ALU_RI = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_IN     = 3'd4,
    OP_OUT    = 3'd5,
    OP_JUMP   = 3'd6,
    OP_CTRL   = 3'd7
  } opclass_t;

  typedef enum logic [2:0] {
    JMP_ALWAYS = 3'd0,
    JMP_Z      = 3'd1,
    JMP_NZ     = 3'd2,
    JMP_C      = 3'd3,
    JMP_NC     = 3'd4
  } jmp_func_t;

  typedef enum logic [2:0] {
    CTRL_CALL = 3'd0,
    CTRL_RET  = 3'd1,
    CTRL_HALT = 3'd7
  } ctrl_func_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_MEM    = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] REGMUX_ALU  = 2'd0;
  localparam logic [1:0] REGMUX_DATA = 2'd1;
  localparam logic [1:0] REGMUX_PORT = 2'd2;

  // Unassigned function codes (5..7) fall through to "not taken",
  // which makes them behave as NOPs.
  function automatic logic jump_taken(input logic [2:0] func,
                                      input logic       z,
                                      input logic       c);
    logic taken;
    taken = 1'b0;
    case (jmp_func_t'(func))
      JMP_ALWAYS: taken = 1'b1;
      JMP_Z:      taken = z;
      JMP_NZ:     taken = ~z;
      JMP_C:      taken = c;
      JMP_NC:     taken = ~c;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cpu_control_unit_call_stack.sv
// -----------------------------------------------------------------------------
// cpu_control_unit_call_stack
// Circular return-address stack (LIFO) of DEPTH x WIDTH entries.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data at the top and advance the pointer
//   pop         - retreat the pointer; pop_data is the current top (comb.)
//   push_data   - return address to save
//   pop_data    - entry just below the pointer (valid in the pop cycle)
//   err         - sticky: push while full or pop while empty
// Overflow overwrites the oldest entry because the pointer simply wraps;
// underflow returns whatever sits at the wrapped pointer.
// -----------------------------------------------------------------------------
module cpu_control_unit_call_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             err
);

  localparam int           SP_W = $clog2(DEPTH);
  localparam logic [SP_W:0] FULL = (SP_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp_reg;
  logic [SP_W-1:0]  top_idx;
  logic [SP_W:0]    count_reg;
  logic             err_reg;

  assign top_idx  = sp_reg - SP_W'(1);
  assign pop_data = mem[top_idx];
  assign err      = err_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[gi] <= '0;
      end else if (push && (sp_reg == SP_W'(gi))) begin
        mem[gi] <= push_data;
      end
    end
  end

  // count_reg tracks real occupancy so over/underflow can be flagged even
  // though the pointer itself wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_reg    <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (push) begin
      sp_reg <= sp_reg + SP_W'(1);
      if (count_reg == FULL) begin
        err_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + (SP_W+1)'(1);
      end
    end else if (pop) begin
      sp_reg <= top_idx;
      if (count_reg == '0) begin
        err_reg <= 1'b1;
      end else begin
        count_reg <= count_reg - (SP_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_control_unit
// Sequencer driving the processing unit (PU): fetches instructions, decodes
// the PU's op/func fields, runs the data-memory and I/O-port handshakes and
// resolves jumps, calls and returns.
//   clk_i, rst_i                  - clock, asynchronous active-low reset
//   inst_cyc_o/stb_o/adr_o/ack_i  - instruction bus (adr = PC)
//   data_cyc_o/stb_o/we_o/ack_i   - data-memory bus (LOAD/STORE)
//   port_cyc_o/stb_o/we_o/ack_i   - I/O port bus (IN/OUT)
//   op_i, func_i, addr_i          - decoded fields from the PU IR
//   carry_i, zero_i               - ALU flags, latched at the end of EXEC
//   clkEn_o, RegWrt_o, ALUOp_o,
//   RegMux_o, op2_o               - PU datapath controls
//   halted_o                      - core stopped by HALT (reset to leave)
//   stack_err_o                   - sticky return-stack over/underflow
// -----------------------------------------------------------------------------
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            inst_cyc_o,
  output logic            inst_stb_o,
  output logic [PC_W-1:0] inst_adr_o,
  input  logic            inst_ack_i,
  output logic            data_cyc_o,
  output logic            data_stb_o,
  output logic            data_we_o,
  input  logic            data_ack_i,
  output logic            port_cyc_o,
  output logic            port_stb_o,
  output logic            port_we_o,
  input  logic            port_ack_i,
  input  logic [2:0]      op_i,
  input  logic [2:0]      func_i,
  input  logic [PC_W-1:0] addr_i,
  input  logic            carry_i,
  input  logic            zero_i,
  output logic            clkEn_o,
  output logic            RegWrt_o,
  output logic [3:0]      ALUOp_o,
  output logic [1:0]      RegMux_o,
  output logic            op2_o,
  output logic            halted_o,
  output logic            stack_err_o
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next, pc_inc;
  logic            z_reg, z_next;
  logic            c_reg, c_next;
  logic            push, pop;
  logic [PC_W-1:0] pop_data;
  opclass_t        op_class;
  logic            mem_is_port, mem_is_write, mem_ack;

  assign op_class   = opclass_t'(op_i);
  assign pc_inc     = pc_reg + PC_W'(1);   // wraps modulo 2^PC_W
  assign inst_adr_o = pc_reg;

  // Bus routing for the MEM state: port bus for IN/OUT, data bus otherwise.
  // Only the ack of the bus actually strobed is looked at.
  assign mem_is_port  = (op_class == OP_IN) || (op_class == OP_OUT);
  assign mem_is_write = (op_class == OP_STORE) || (op_class == OP_OUT);
  assign mem_ack      = mem_is_port ? port_ack_i : data_ack_i;

  cpu_control_unit_call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_call_stack (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .err       (stack_err_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      z_reg     <= z_next;
      c_reg     <= c_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    z_next     = z_reg;
    c_next     = c_reg;
    push       = 1'b0;
    pop        = 1'b0;
    inst_cyc_o = 1'b0;
    inst_stb_o = 1'b0;
    data_cyc_o = 1'b0;
    data_stb_o = 1'b0;
    data_we_o  = 1'b0;
    port_cyc_o = 1'b0;
    port_stb_o = 1'b0;
    port_we_o  = 1'b0;
    clkEn_o    = 1'b0;
    RegWrt_o   = 1'b0;
    ALUOp_o    = 4'h0;
    RegMux_o   = REGMUX_ALU;
    op2_o      = 1'b0;
    halted_o   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        inst_cyc_o = 1'b1;
        inst_stb_o = 1'b1;
        if (inst_ack_i) begin
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (op_class)
          OP_ALU_RR, OP_ALU_RI: begin
            state_next = ST_EXEC;
          end
          OP_LOAD, OP_STORE, OP_IN, OP_OUT: begin
            state_next = ST_MEM;
          end
          OP_JUMP: begin
            pc_next    = jump_taken(func_i, z_reg, c_reg) ? addr_i : pc_inc;
            state_next = ST_FETCH;
          end
          OP_CTRL: begin
            state_next = ST_FETCH;
            case (ctrl_func_t'(func_i))
              CTRL_CALL: begin
                push    = 1'b1;          // saves pc_inc
                pc_next = addr_i;
              end
              CTRL_RET: begin
                pop     = 1'b1;
                pc_next = pop_data;
              end
              CTRL_HALT: begin
                state_next = ST_HALT;
              end
              default: begin
                pc_next = pc_inc;
              end
            endcase
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end

      ST_EXEC: begin
        clkEn_o    = 1'b1;
        ALUOp_o    = {1'b0, func_i};
        op2_o      = (op_class == OP_ALU_RR);
        z_next     = zero_i;
        c_next     = carry_i;
        state_next = ST_WB;
      end

      ST_WB: begin
        clkEn_o    = 1'b1;
        RegWrt_o   = 1'b1;
        RegMux_o   = REGMUX_ALU;
        pc_next    = pc_inc;
        state_next = ST_FETCH;
      end

      ST_MEM: begin
        if (mem_is_port) begin
          port_cyc_o = 1'b1;
          port_stb_o = 1'b1;
          port_we_o  = mem_is_write;
        end else begin
          data_cyc_o = 1'b1;
          data_stb_o = 1'b1;
          data_we_o  = mem_is_write;
        end
        if (mem_ack) begin
          // Reads write back in the ack cycle, while the bus data is valid.
          if (!mem_is_write) begin
            clkEn_o  = 1'b1;
            RegWrt_o = 1'b1;
            RegMux_o = mem_is_port ? REGMUX_PORT : REGMUX_DATA;
          end
          pc_next    = pc_inc;
          state_next = ST_FETCH;
        end
      end

      ST_HALT: begin
        halted_o = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Sequencer that sits directly upstream of the processing unit (PU) and drives all of its control inputs.
- Fetches 18-bit instructions over the instruction bus and decodes the PU's op/func fields.
- Drives clkEn/RegWrt/ALUOp/RegMux/op2, runs the data-memory and I/O-port bus handshakes, and resolves jumps, calls and returns.
- Owns the 12-bit program counter, the latched Z/C flags and an 8-entry return stack.

Parameters:
- PC_W, 12, program counter / instruction address width.
- STACK_DEPTH, 8, return-stack entries (power of 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- inst_cyc_o  out  1  instruction bus cycle.
- inst_stb_o  out  1  instruction bus strobe.
- inst_adr_o  out  PC_W  instruction address (= PC).
- inst_ack_i  in  1  instruction ack; the PU IR latches the instruction on this.
- data_cyc_o / data_stb_o / data_we_o  out  1 each  data-memory bus control.
- data_ack_i  in  1  data-memory ack.
- port_cyc_o / port_stb_o / port_we_o  out  1 each  I/O port bus control.
- port_ack_i  in  1  port ack.
- op_i  in  3  opcode class from PU.
- func_i  in  3  function field from PU.
- addr_i  in  PC_W  jump/call target from PU.
- carry_i  in  1  ALU carry from PU (combinational).
- zero_i  in  1  ALU zero from PU (combinational).
- clkEn_o  out  1  PU register-bank / carry-register enable.
- RegWrt_o  out  1  PU register write.
- ALUOp_o  out  4  ALU operation.
- RegMux_o  out  2  writeback select: 0 ALU, 1 data, 2 port.
- op2_o  out  1  1 = rs2 operand, 0 = immediate.
- halted_o  out  1  core is halted.
- stack_err_o  out  1  sticky return-stack overflow/underflow.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, PC=0, Z=C=0, stack pointer=0, stack_err_o=0.
  - Every output is 0.
- Opcode classes (op_i):
  - 0 ALU reg-reg, 1 ALU reg-imm, 2 LOAD, 3 STORE, 4 IN, 5 OUT, 6 JUMP, 7 CTRL.
- JUMP func_i: 0 JMP, 1 JZ, 2 JNZ, 3 JC, 4 JNC; 5-7 NOP.
- CTRL func_i: 0 CALL, 1 RET, 7 HALT; others NOP.
- FSM states:
  - IDLE: one cycle after reset release, no outputs asserted -> FETCH.
  - FETCH:
    - inst_cyc_o=inst_stb_o=1, inst_adr_o=PC.
    - Hold until inst_ack_i; zero-wait ack in the same cycle is legal.
    - On ack -> DECODE.
  - DECODE (1 cycle): op/func are valid.
    - ALU classes -> EXEC.
    - LOAD/STORE/IN/OUT -> MEM.
    - JUMP: if taken PC<=addr_i, else PC<=PC+1; -> FETCH.
    - CALL: push PC+1, PC<=addr_i; -> FETCH.
    - RET: PC<=pop; -> FETCH.
    - HALT -> HALT.
    - NOP: PC<=PC+1; -> FETCH.
  - EXEC (1 cycle):
    - clkEn_o=1, ALUOp_o={1'b0,func_i}, op2_o=(op_i==0).
    - Z<=zero_i and C<=carry_i at the end of the cycle.
    - -> WB.
  - WB (1 cycle):
    - clkEn_o=1, RegWrt_o=1, RegMux_o=0.
    - PC<=PC+1; -> FETCH.
  - MEM:
    - Bus selection: LOAD/STORE use data_*; IN/OUT use port_*.
    - cyc=stb=1 on the selected bus; we=1 for STORE/OUT.
    - Hold until ack.
    - For LOAD/IN, the ack cycle also asserts clkEn_o=1, RegWrt_o=1, RegMux_o=1 (LOAD) or 2 (IN).
    - On ack: PC<=PC+1; -> FETCH.
  - HALT: halted_o=1, all strobes 0. Exit only via reset.
- Outside EXEC, ALUOp_o=0 and op2_o=0.
- Strobes are deasserted in the cycle after ack; there are no back-to-back cycles without passing through FETCH/DECODE.
- Minimum latency per instruction (zero-wait bus):
  - ALU: 4 cycles.
  - LOAD/STORE/IN/OUT: 3 cycles.
  - JUMP/CALL/RET/NOP: 2 cycles.
- PC arithmetic is modulo 2^PC_W; 0xFFF+1 wraps to 0.
- Return stack is circular:
  - Push when full overwrites the oldest entry.
  - Pop when empty returns the entry at the wrapped pointer.
  - Both cases set stack_err_o, which stays set until reset.
- A spurious ack on a bus that is not strobed is ignored.
- Reset mid-transaction drops all strobes immediately (async). The restart is IDLE -> FETCH at PC=0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opclass_t enum (8 classes).
  - jmp_func_t and ctrl_func_t enums.
  - state_t enum (IDLE, FETCH, DECODE, EXEC, WB, MEM, HALT).
  - RegMux constants REGMUX_ALU=0, REGMUX_DATA=1, REGMUX_PORT=2.
- One sub-module, call_stack: STACK_DEPTH x PC_W circular LIFO with push/pop/data and err output.

Test Plan:
- ALU flow: reset; fetch ALU reg-reg func=3 with zero-wait ack -> FETCH, DECODE, EXEC (clkEn_o=1, ALUOp_o=4'h3, op2_o=1), WB (RegWrt_o=1, RegMux_o=0); inst_adr_o goes 0->1 after 4 cycles.
- LOAD with data ack delayed 3 cycles -> data_stb_o high for 4 cycles; RegWrt_o=1 and RegMux_o=1 only in the ack cycle; PC increments once.
- Conditional branch: EXEC with zero_i=1 latches Z=1; then JZ addr=0x2A0 -> next inst_adr_o=0x2A0. Same flow with zero_i=0 -> PC+1.
- CALL/RET: CALL 0x100 from PC=0x010, then RET -> PC=0x011. Nine nested CALLs -> stack_err_o=1; the ninth RET returns the wrapped entry.
- HALT and reset: OUT with port_ack_i delayed, then HALT -> halted_o=1 with all strobes 0. Reset asserted while inst_stb_o=1 -> inst_stb_o=0 immediately; after release, IDLE then FETCH at adr 0.
